// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO and issue controller sitting directly in front of the UART
// transmitter. Bytes arrive on a valid/ready write port, are buffered in a
// synchronous FIFO and are handed to the transmitter one frame at a time.
// A byte is only issued while the transmitter reports idle.
//
// Optional feature: define UART_TX_FEEDER_CHECKSUM_EN to append an XOR
// checksum frame after every byte written with i_wr_last set.
//
// A byte written into an empty FIFO becomes visible to the issue side on
// the following edge (o_empty lags the write by one edge). Pops are seen
// immediately, so the FIFO can never be over-read.

module uart_tx_feeder #(
    parameter int D_BITS = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [D_BITS-1:0]          i_wr_data,
    input  logic                       i_wr_valid,
    input  logic                       i_wr_last,
    output logic                       o_wr_ready,
    output logic [D_BITS-1:0]          o_tx_data,
    output logic                       o_tx_enable,
    input  logic                       i_tx_idle,
    input  logic                       i_tx_done,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

`ifdef UART_TX_FEEDER_CHECKSUM_EN
    localparam int FW = D_BITS + 1;
`else
    localparam int FW = D_BITS;
`endif

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT       = 3'd2;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM_ISSUE = 3'd3;
    localparam logic [2:0] ST_CSUM_WAIT  = 3'd4;
`endif

    logic [FW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_nxt;
    logic [PW-1:0]     level_nxt;
    logic [FW-1:0]     wr_entry;
    logic [FW-1:0]     head;
    logic [D_BITS-1:0] head_data;
    logic              do_write;
    logic              do_pop;
    logic [2:0]        state;

`ifdef UART_TX_FEEDER_CHECKSUM_EN
    logic              head_last;
    logic              last_q;
    logic [D_BITS-1:0] acc;

    assign wr_entry  = {i_wr_last, i_wr_data};
    assign head_data = head[D_BITS-1:0];
    assign head_last = head[D_BITS];
`else
    logic unused_wr_last;

    assign unused_wr_last = i_wr_last;
    assign wr_entry       = i_wr_data;
    assign head_data      = head;
`endif

    assign head       = mem[rd_ptr[AW-1:0]];
    assign do_write   = i_wr_valid && o_wr_ready;
    assign do_pop     = (state == ST_IDLE) && !o_empty && i_tx_idle;
    assign wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, do_write};
    assign rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, do_pop};
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    // FIFO storage: accepted writes land at the write pointer slot
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Pointer and status registers; empty uses the old write pointer so a fresh byte is visible one edge later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_full     <= 1'b0;
            o_wr_ready <= 1'b1;
            o_empty    <= 1'b1;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            o_level    <= level_nxt;
            o_full     <= (level_nxt == PW'(DEPTH));
            o_wr_ready <= (level_nxt != PW'(DEPTH));
            o_empty    <= (wr_ptr == rd_ptr_nxt);
        end
    end

    // Issue state machine: pop when the transmitter is idle, strobe once, then wait for its done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_tx_data <= '0;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
            last_q    <= 1'b0;
            acc       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_pop) begin
                        o_tx_data <= head_data;
                        state     <= ST_ISSUE;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                        last_q    <= head_last;
                        acc       <= acc ^ head_data;
`endif
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                        if (last_q) begin
                            o_tx_data <= acc;
                            state     <= ST_CSUM_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                ST_CSUM_ISSUE: begin
                    state <= ST_CSUM_WAIT;
                end
                ST_CSUM_WAIT: begin
                    if (i_tx_done) begin
                        acc    <= '0;
                        last_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_CHECKSUM_EN
    assign o_tx_enable = (state == ST_ISSUE) || (state == ST_CSUM_ISSUE);
`else
    assign o_tx_enable = (state == ST_ISSUE);
`endif
    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder. Expected transmit bytes are queued when
// stimulus is issued; a monitor pops and compares on every o_tx_enable strobe.
// A small transmitter model answers each strobe with a done pulse.

module tb_uart_tx_feeder;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_wr_data;
    logic       i_wr_valid;
    logic       i_wr_last;
    logic       o_wr_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_enable;
    logic       i_tx_idle;
    logic       i_tx_done;
    logic [4:0] o_level;
    logic       o_empty;
    logic       o_full;
    logic       o_busy;

    logic       auto_tx;
    logic       idle_allow;
    logic       model_idle;
    logic       model_done;
    logic       manual_done;

    logic [7:0] exp_q [$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         strobe_cnt  = 0;
    int         strobe_cyc  = 0;
    int         wr_cyc      = 0;

    assign i_tx_idle = model_idle & idle_allow;
    assign i_tx_done = model_done | manual_done;

    uart_tx_feeder #(.D_BITS(8), .DEPTH(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_data   (i_wr_data),
        .i_wr_valid  (i_wr_valid),
        .i_wr_last   (i_wr_last),
        .o_wr_ready  (o_wr_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_enable (o_tx_enable),
        .i_tx_idle   (i_tx_idle),
        .i_tx_done   (i_tx_done),
        .o_level     (o_level),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_busy      (o_busy)
    );

    // Free-running clock
    always #5 i_clk = ~i_clk;

    // Edge counter used to measure issue latency
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last);
        i_wr_data  = d;
        i_wr_last  = last;
        i_wr_valid = 1'b1;
        @(posedge i_clk);
        #1;
        wr_cyc     = cyc;
        i_wr_valid = 1'b0;
        i_wr_last  = 1'b0;
    endtask

    task automatic waitStrobe(input int s0, input string name);
        int n = 0;
        while (strobe_cnt == s0 && n < 30) begin
            tick();
            n++;
        end
        checkOutput(name, (strobe_cnt != s0), 1);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !o_busy) break;
        end
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_enable"}, o_tx_enable, 0);
        checkOutput({tag, "_tx_data"},   o_tx_data,   0);
        checkOutput({tag, "_wr_ready"},  o_wr_ready,  1);
        checkOutput({tag, "_level"},     o_level,     0);
        checkOutput({tag, "_empty"},     o_empty,     1);
        checkOutput({tag, "_full"},      o_full,      0);
        checkOutput({tag, "_busy"},      o_busy,      0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected byte
    always @(negedge i_clk) begin
        if (i_rst_n && o_tx_enable) begin
            strobe_cnt++;
            strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_strobe: got data %0h, expected no strobe", o_tx_data);
            end else begin
                checkOutput("tx_data", o_tx_data, exp_q.pop_front());
            end
        end
    end

    // Transmitter model: busy for a few cycles after each strobe, then a done pulse
    initial begin
        model_idle = 1'b1;
        model_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_enable && auto_tx) begin
                model_idle = 1'b0;
                repeat (4) @(negedge i_clk);
                model_done = 1'b1;
                model_idle = 1'b1;
                @(negedge i_clk);
                model_done = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int s0;
        i_rst_n     = 1'b0;
        i_wr_data   = 8'h00;
        i_wr_valid  = 1'b0;
        i_wr_last   = 1'b0;
        auto_tx     = 1'b1;
        idle_allow  = 1'b1;
        manual_done = 1'b0;
        #12;
        checkResetValues("reset");
        tick();
        i_rst_n = 1'b1;
        tick();

        // Single byte: strobe two edges after acceptance, busy until done
        $display("[TB] single byte");
        s0 = strobe_cnt;
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b0);
        waitStrobe(s0, "single_strobe_seen");
        checkOutput("single_latency", strobe_cyc - wr_cyc, 2);
        for (int i = 0; i < 20 && !i_tx_done; i++) tick();
        checkOutput("busy_before_done", o_busy, 1);
        tick();
        checkOutput("busy_after_done", o_busy, 0);
        checkOutput("strobe_count_single", strobe_cnt - s0, 1);

        // Fill and overflow with the transmitter held non-idle
        $display("[TB] fill/overflow");
        idle_allow = 1'b0;
        for (int i = 0; i < 17; i++) begin
            i_wr_data  = 8'(i);
            i_wr_valid = 1'b1;
            if (i < 16) exp_q.push_back(8'(i));
            if (i == 16) checkOutput("wr_ready_when_full", o_wr_ready, 0);
            @(posedge i_clk);
            #1;
        end
        i_wr_valid = 1'b0;
        tick();
        checkOutput("full_flag", o_full, 1);
        checkOutput("full_level", o_level, 16);
        idle_allow = 1'b1;
        waitDrain(600);
        checkOutput("level_after_drain", o_level, 0);

        // Idle gating: nothing issues while the transmitter is not idle
        $display("[TB] idle gating");
        idle_allow = 1'b0;
        exp_q.push_back(8'h5C);
        applyStimulus(8'h5C, 1'b0);
        s0 = strobe_cnt;
        repeat (50) tick();
        checkOutput("gated_strobes", strobe_cnt - s0, 0);
        idle_allow = 1'b1;
        wr_cyc = cyc;
        waitStrobe(s0, "gated_strobe_seen");
        checkOutput("gated_release_latency", strobe_cyc - wr_cyc, 1);
        waitDrain(100);

        // Simultaneous write and pop at level 3
        $display("[TB] simultaneous write/pop");
        idle_allow = 1'b0;
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h24);
        applyStimulus(8'h21, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h23, 1'b0);
        tick();
        tick();
        checkOutput("level_before_simul", o_level, 3);
        idle_allow = 1'b1;
        applyStimulus(8'h24, 1'b0);
        checkOutput("level_simul", o_level, 3);
        waitDrain(200);

        // Reset while waiting for done with five bytes still queued
        $display("[TB] reset mid-wait");
        auto_tx    = 1'b0;
        idle_allow = 1'b0;
        exp_q.push_back(8'h30);
        for (int i = 0; i < 6; i++) applyStimulus(8'h30 + 8'(i), 1'b0);
        tick();
        s0 = strobe_cnt;
        idle_allow = 1'b1;
        waitStrobe(s0, "midwait_strobe_seen");
        tick();
        tick();
        checkOutput("midwait_level", o_level, 5);
        checkOutput("midwait_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        tick();
        i_rst_n = 1'b1;
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        s0 = strobe_cnt;
        repeat (10) tick();
        checkOutput("post_reset_strobes", strobe_cnt - s0, 0);
        checkOutput("post_reset_level", o_level, 0);
        auto_tx = 1'b1;

`ifdef UART_TX_FEEDER_CHECKSUM_EN
        // Checksum frames after each packet
        $display("[TB] checksum");
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h70);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h56, 1'b1);
        waitDrain(200);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        applyStimulus(8'h01, 1'b1);
        waitDrain(200);
`endif

        tick();
        checkOutput("queue_empty_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
